seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Multiplexed 8-digit seven-segment scan driver sitting downstream of confreg's 32-bit seg
//  register, between the SoC top and board pins. Latches the hex value once per frame to avoid
//  tearing, scans one digit per slot with anti-ghosting guard time, decodes each nibble to
//  active-low cathodes, and optionally blanks leading zeros.
// PARAMETERS
//  NUM_DIGITS  8       digits scanned; seg_value width is 4*NUM_DIGITS; nibble i -> digit i
//  CLK_DIV     100000  clk cycles per digit slot; legal range 2..2^24
//  GUARD       2       cycles at start of each slot with all anodes off; 0 <= GUARD < CLK_DIV
// PORTS
//  clk         in   1             system clock
//  reset       in   1             synchronous, active-high reset
//  seg_value   in   4*NUM_DIGITS  hex value from confreg seg register
//  blank_lz    in   1             1 = blank leading-zero digits
//  an_n        out  NUM_DIGITS    digit anodes, active-low, bit i = digit i
//  cath_n      out  8             cathodes {dp,g,f,e,d,c,b,a}, active-low
//  frame_done  out  1             one-cycle pulse at end of each full scan frame
// BEHAVIOUR
//  Reset: cnt=0, idx=0, snap=0, load_pend=1; an_n=all 1, cath_n=8'hFF, frame_done=0 in the
//   cycle after reset is sampled high. Reset wins over every other event, including mid-slot.
//  Prescaler: cnt counts 0..CLK_DIV-1 and wraps; tick = (cnt==CLK_DIV-1).
//  Digit index: on tick idx increments, wrapping NUM_DIGITS-1 -> 0.
//  Snapshot: snap <= seg_value when load_pend=1 (first cycle after reset release; clears
//   load_pend) or when tick && idx==NUM_DIGITS-1. seg_value is ignored at all other times.
//  frame_done: registered; asserted for the cycle after tick && idx==NUM_DIGITS-1
//   (i.e. in step with the new snapshot). Period = NUM_DIGITS*CLK_DIV cycles.
//  Blanking: digit i blank iff blank_lz=1, i>0, and snap nibbles i..NUM_DIGITS-1 all zero.
//   Digit 0 is never blanked. blank_lz is sampled live, not snapshotted.
//  Output register (one-cycle latency from cnt/idx/snap):
//   if cnt < GUARD or digit idx blank: an_n <= all 1, cath_n <= 8'hFF
//   else an_n <= ~(1<<idx), cath_n <= font(snap[4*idx+:4]).
//   At most one an_n bit is ever low. dp (cath_n[7]) is always 1.
//  Font (active-low): 0 C0 1 F9 2 A4 3 B0 4 99 5 92 6 82 7 F8 8 80 9 90 A 88 b 83 C C6
//   d A1 E 86 F 8E.
//  No X propagation: font decode fully specified for all 16 nibble values.
// TESTING  (bench params NUM_DIGITS=8, CLK_DIV=4, GUARD=1)
//  1 Hold reset 3 cycles -> an_n=8'hFF, cath_n=8'hFF, frame_done=0 throughout and 1 cycle after.
//  2 seg_value=32'h0123_4567, blank_lz=0 -> slot0: an_n FF for 1 cycle then FE x3 with
//    cath_n F8; slot7: an_n 7F, cath_n C0; frame_done pulses every 32 cycles.
//  3 Change seg_value to 32'hFFFF_FFFF mid-frame -> digits keep old values until frame_done,
//    then all digits show 8E.
//  4 blank_lz=1, seg_value=32'h0000_00A0 -> digits 0,1 show C0,88; slots 2-7 an_n=FF;
//    seg_value=0 -> only digit 0 lights (C0).
//  5 Assert reset during slot 5 -> next cycle an_n=FF, then scan restarts at digit 0 with a
//    freshly loaded snapshot.
//  6 Scan 16 values 0..F through digit 0 -> cath_n matches font table exactly; never two an_n
//    bits low in any cycle (assertion).

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: snapshots the hex value once per frame,
// scans one digit per slot with a dark guard window, optional leading-zero blanking.
module seg_scan_driver #(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_DIV    = 100000,
   parameter int GUARD      = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   seg_value,
   input  logic                      blank_lz,
   output logic [NUM_DIGITS-1:0]     an_n,
   output logic [7:0]                cath_n,
   output logic                      frame_done
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]          cnt;
   logic [IDX_W-1:0]          idx;
   logic [4*NUM_DIGITS-1:0]   snap;
   logic                      load_pend;
   logic                      tick;
   logic                      last_slot;
   logic                      zero_run;
   logic [NUM_DIGITS-1:0]     blank_mask;
   logic [3:0]                nib;

   function automatic logic [7:0] font(input logic [3:0] n);
      case (n)
         4'h0:    font = 8'hC0;
         4'h1:    font = 8'hF9;
         4'h2:    font = 8'hA4;
         4'h3:    font = 8'hB0;
         4'h4:    font = 8'h99;
         4'h5:    font = 8'h92;
         4'h6:    font = 8'h82;
         4'h7:    font = 8'hF8;
         4'h8:    font = 8'h80;
         4'h9:    font = 8'h90;
         4'hA:    font = 8'h88;
         4'hB:    font = 8'h83;
         4'hC:    font = 8'hC6;
         4'hD:    font = 8'hA1;
         4'hE:    font = 8'h86;
         4'hF:    font = 8'h8E;
         default: font = 8'hFF;
      endcase
   endfunction

   assign tick      = (cnt == CNT_MAX);
   assign last_slot = tick && (idx == IDX_MAX);
   assign nib       = snap[4*idx +: 4];

   // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
   always_comb begin
      blank_mask = '0;
      zero_run   = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run      = zero_run & (snap[4*i +: 4] == 4'h0);
         blank_mask[i] = blank_lz & zero_run;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= '0;
         snap       <= '0;
         load_pend  <= 1'b1;
         an_n       <= '1;
         cath_n     <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick)
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
         if (load_pend || last_slot)
            snap <= seg_value;
         load_pend  <= 1'b0;
         frame_done <= last_slot;
         if (cnt < GUARD_C || blank_mask[idx]) begin
            an_n   <= '1;
            cath_n <= 8'hFF;
         end else begin
            an_n   <= ~(NUM_DIGITS'(1) << idx);
            cath_n <= font(nib);
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (8 digits, 4-cycle slots, 1-cycle guard) with
// a queue scoreboard of expected per-cycle outputs.
module tb_seg_scan_driver;

   localparam int ND = 8;
   localparam int CD = 4;
   localparam int GD = 1;
   localparam int FRAME = ND * CD;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] seg_value;
   logic        blank_lz;
   logic [7:0]  an_n;
   logic [7:0]  cath_n;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      tag;
      logic [7:0] an;
      logic [7:0] cath;
      logic       fd;
   } exp_t;

   exp_t sb[$];

   logic [7:0] font_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   seg_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .GUARD(GD)) dut (
      .clk        (clk),
      .reset      (reset),
      .seg_value  (seg_value),
      .blank_lz   (blank_lz),
      .an_n       (an_n),
      .cath_n     (cath_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Anti-ghosting: never more than one anode driven low.
   always @(negedge clk) begin
      if (!$isunknown(an_n)) begin
         checks++;
         assert ($countones(~an_n) <= 1) else begin
            errors++;
            $error("FAIL one_hot an_n got %h exp at most one low bit", an_n);
         end
      end
   end

   function automatic bit is_blank(input logic [31:0] v, input logic b, input int d);
      return b && (d > 0) && ((v >> (4*d)) == 32'h0);
   endfunction

   task automatic push_exp(input string tag, input logic [7:0] an, input logic [7:0] cath,
                           input logic fd);
      exp_t e;
      e.tag  = tag;
      e.an   = an;
      e.cath = cath;
      e.fd   = fd;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         checks++;
         $error("FAIL scoreboard_empty got 0 entries exp 1");
         return;
      end
      e = sb.pop_front();
      checks += 3;
      assert (an_n === e.an) else begin
         errors++;
         $error("FAIL %s an_n got %h exp %h", e.tag, an_n, e.an);
      end
      assert (cath_n === e.cath) else begin
         errors++;
         $error("FAIL %s cath_n got %h exp %h", e.tag, cath_n, e.cath);
      end
      assert (frame_done === e.fd) else begin
         errors++;
         $error("FAIL %s frame_done got %b exp %b", e.tag, frame_done, e.fd);
      end
   endtask

   // Checks one frame showing val; seg_value switches to next_val mid-frame.
   // Stops after cycle stop_at when stop_at >= 0.
   task automatic run_frame(input string name, input logic [31:0] val, input logic blz,
                            input logic [31:0] next_val, input int stop_at);
      blank_lz = blz;
      for (int j = 0; j < FRAME; j++) begin
         int d;
         int ph;
         string tag;
         d   = j / CD;
         ph  = j % CD;
         tag = $sformatf("%s_d%0d_p%0d", name, d, ph);
         if (j == 10)
            seg_value = next_val;
         if (ph < GD || is_blank(val, blz, d))
            push_exp(tag, 8'hFF, 8'hFF, j == FRAME - 1);
         else
            push_exp(tag, ~(8'h01 << d), font_tbl[val[4*d +: 4]], j == FRAME - 1);
         @(negedge clk);
         pop_check();
         if (j == stop_at)
            return;
      end
   endtask

   initial begin
      logic [3:0] nv;
      reset     = 1'b1;
      blank_lz  = 1'b0;
      seg_value = 32'h0123_4567;

      // reset held three cycles
      for (int k = 0; k < 3; k++) begin
         push_exp($sformatf("reset_%0d", k), 8'hFF, 8'hFF, 1'b0);
         @(negedge clk);
         pop_check();
      end
      reset = 1'b0;

      run_frame("basic_a", 32'h0123_4567, 1'b0, 32'h0123_4567, -1);
      run_frame("midchg", 32'h0123_4567, 1'b0, 32'hFFFF_FFFF, -1);
      run_frame("all_f", 32'hFFFF_FFFF, 1'b0, 32'h0000_00A0, -1);
      run_frame("blank_a0", 32'h0000_00A0, 1'b1, 32'h0000_0000, -1);
      run_frame("blank_0", 32'h0000_0000, 1'b1, 32'h0000_0000, -1);

      // reset asserted in slot 5, new value presented while in reset
      run_frame("pre_rst", 32'h0000_0000, 1'b0, 32'h0000_0000, 5*CD + 1);
      reset     = 1'b1;
      seg_value = 32'h89AB_CDEF;
      push_exp("rst_mid", 8'hFF, 8'hFF, 1'b0);
      @(negedge clk);
      pop_check();
      reset = 1'b0;
      run_frame("post_rst", 32'h89AB_CDEF, 1'b0, 32'h0000_0000, -1);

      // every nibble value through the font
      for (int v = 0; v < 16; v++) begin
         logic [3:0] cv;
         cv = 4'(v);
         nv = 4'(v + 1);
         run_frame($sformatf("font_%0d", v), {8{cv}}, 1'b0, {8{nv}}, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
